vga_timing_640_480: RTL
=======================

# vga_timing_640_480

- Timing controller that sequences the 640x480@60 Hz pixel pattern generator.
- Counts pixel-enable strobes and runs one four-phase state machine per axis: horizontal (pixel) and vertical (line).
- Produces the sync pulses, the active-area address enables and the pixel/line indices consumed by the generator.
- Also produces frame-start and line-start pulses for downstream logic (e.g. frame-buffer fetch).

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  system clock; one clock, all logic on rising edge
- i_sclr  in  1  reset; synchronous, active-high; priority over everything
- i_px_clk  in  1  pixel-enable strobe, one clk wide (e.g. every 4th clk for 25 MHz)
- o_hsync_en  out  1  high during the horizontal sync phase
- o_vsync_en  out  1  high during the vertical sync phase
- o_vga_hs, o_vga_vs  out  1 each  pin-level syncs, active-low (~o_hsync_en, ~o_vsync_en)
- o_haddr_en, o_vaddr_en  out  1 each  high in the horizontal / vertical active phase
- o_hidx  out  10  pixel column 0..639 while o_haddr_en, else 0
- o_vidx  out  9  line 0..479 while o_vaddr_en, else 0
- o_line_start  out  1  one-clk pulse when the horizontal position wraps to 0
- o_frame_start  out  1  one-clk pulse when both positions wrap to (0,0)

## Operation
- Horizontal FSM states, in order: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - Each state has a phase counter that runs 0..len-1; the last count moves to the next state with the phase counter at 0.
  - Defaults give position 0-639 active, 640-655 front, 656-751 sync, 752-799 back: 800 total.
- Vertical FSM: identical structure with the V_* lengths.
  - Lines 0-479 active, 480-489 front, 490-491 sync, 492-524 back: 525 total.
- Horizontal steps on every clk with i_px_clk=1.
- Vertical steps only when i_px_clk=1 and the horizontal FSM leaves BACK at its last count (horizontal wrap).
- All vertical outputs therefore change on the same clk edge as the horizontal wrap to 0.
- o_hidx / o_vidx equal the ACTIVE phase counter of their axis; they are forced to 0 outside ACTIVE.
- o_line_start: set to 1 for exactly one clk on the edge that enters horizontal position 0; 0 otherwise. It does not repeat across idle clks between strobes.
- o_frame_start: same rule, but only when that edge also enters vertical position 0.
- Reset state: both FSMs in ACTIVE with phase counters at 0.
  - Outputs: o_haddr_en=1, o_vaddr_en=1, o_hidx=0, o_vidx=0.
  - o_hsync_en=0, o_vsync_en=0, o_vga_hs=1, o_vga_vs=1.
  - o_line_start=0, o_frame_start=0.
  - Reset does not emit a start pulse; the first o_frame_start occurs at the first full-frame wrap.

## Timing
- All outputs are registered and change only on clk edges where i_px_clk=1 or i_sclr=1.
- Latency from a strobe to its outputs: the outputs describe the new position on the clk edge that consumes the strobe.
- i_px_clk held high continuously: the controller advances every clk. It must be fully functional at this rate.
- i_px_clk low: all state and outputs hold, except start pulses, which are cleared after their single clk.
- i_sclr and i_px_clk high together: reset wins and the strobe is dropped.
- i_sclr mid-frame (any state): on the next edge all outputs take their reset values.
- Parameter lengths must each be >= 1. Sums must fit the counters: H total <= 1024, V_ACTIVE <= 512, V total <= 1024.

## Structure
- Shared header vga_params.vh holds:
  - the 640x480 default lengths as localparams;
  - the 2-bit phase encodings ACTIVE=0, FRONT=1, SYNC=2, BACK=3.
- One sub-module, vga_axis_fsm, instantiated twice (horizontal and vertical). It contains:
  - parameters for the four lengths;
  - inputs clk, i_sclr, i_step;
  - outputs: phase state, phase count, wrap, active, sync.
- The top level adds the index masking, the active-low pin inversion and the start-pulse registers.

## Test plan
- Reset then i_px_clk continuously high: o_haddr_en falls after exactly 640 strobes, and o_hsync_en is high for exactly 96 strobes starting at strobe 656.
- Full frame: o_line_start pulses every 800 strobes; o_vsync_en is high for lines 490-491 (1600 strobes); o_frame_start pulses once per 420000 strobes.
- i_px_clk every 4th clk: outputs change only on strobe edges, and o_line_start stays high for exactly one clk.
- Index check: at the strobe entering position (639, 479), o_hidx=639 and o_vidx=479. At the next strobe, o_hidx=0 and o_haddr_en=0 while o_vaddr_en is still 1.
- i_sclr asserted at position (h=700, v=300) with i_px_clk=1: the next edge gives reset values, and the following strobe advances to h=1.
- Small parameters (all lengths 2): the state sequence and wrap timing follow the same rules, with no off-by-one at the length boundaries.

Source files
------------

// File: rtl/vga_timing_640_480_pkg.sv
// Shared 640x480@60 timing defaults and the per-axis phase encoding.
package vga_timing_640_480_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  // Phase counters are sized for an axis total of up to 1024.
  localparam int unsigned CNT_W = 10;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    n = PH_ACTIVE;
    unique case (p)
      PH_ACTIVE: n = PH_FRONT;
      PH_FRONT:  n = PH_SYNC;
      PH_SYNC:   n = PH_BACK;
      PH_BACK:   n = PH_ACTIVE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vga_timing_640_480_axis_fsm.sv
// One timing axis: ACTIVE -> FRONT -> SYNC -> BACK, each phase counted 0..len-1.
module vga_axis_fsm
  import vga_timing_640_480_pkg::*;
#(
  parameter int unsigned ACTIVE_LEN = H_ACTIVE_DEF,
  parameter int unsigned FRONT_LEN  = H_FP_DEF,
  parameter int unsigned SYNC_LEN   = H_SYNC_DEF,
  parameter int unsigned BACK_LEN   = H_BP_DEF
) (
  input  logic             clk,
  input  logic             i_sclr,
  input  logic             i_step,
  output phase_e           o_state,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap,
  output logic             o_active,
  output logic             o_sync
);

  localparam logic [CNT_W-1:0] ACTIVE_LAST = CNT_W'(ACTIVE_LEN - 1);
  localparam logic [CNT_W-1:0] FRONT_LAST  = CNT_W'(FRONT_LEN - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] BACK_LAST   = CNT_W'(BACK_LEN - 1);

  logic [CNT_W-1:0] phase_last;
  logic             at_last;
  phase_e           nxt;

  always_comb begin
    phase_last = ACTIVE_LAST;
    unique case (o_state)
      PH_ACTIVE: phase_last = ACTIVE_LAST;
      PH_FRONT:  phase_last = FRONT_LAST;
      PH_SYNC:   phase_last = SYNC_LAST;
      PH_BACK:   phase_last = BACK_LAST;
    endcase
  end

  assign at_last = (o_count == phase_last);
  assign nxt     = next_phase(o_state);
  // Combinational so the next axis can step on the very edge this one wraps.
  assign o_wrap  = i_step && (o_state == PH_BACK) && at_last;

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      o_state  <= PH_ACTIVE;
      o_count  <= '0;
      o_active <= 1'b1;
      o_sync   <= 1'b0;
    end else if (i_step) begin
      if (at_last) begin
        o_state  <= nxt;
        o_count  <= '0;
        o_active <= (nxt == PH_ACTIVE);
        o_sync   <= (nxt == PH_SYNC);
      end else begin
        o_count <= o_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_timing_640_480.sv
// 640x480@60 timing controller: horizontal and vertical axis FSMs plus start pulses.
module vga_timing_640_480
  import vga_timing_640_480_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_px_clk,
  output logic       o_hsync_en,
  output logic       o_vsync_en,
  output logic       o_vga_hs,
  output logic       o_vga_vs,
  output logic       o_haddr_en,
  output logic       o_vaddr_en,
  output logic [9:0] o_hidx,
  output logic [8:0] o_vidx,
  output logic       o_line_start,
  output logic       o_frame_start
);

  phase_e           h_state, v_state;
  logic [CNT_W-1:0] h_count, v_count;
  logic             h_wrap, v_wrap;
  logic             h_active, v_active;
  logic             h_sync, v_sync;
  logic             state_unused;

  vga_axis_fsm #(
    .ACTIVE_LEN(H_ACTIVE),
    .FRONT_LEN (H_FP),
    .SYNC_LEN  (H_SYNC),
    .BACK_LEN  (H_BP)
  ) u_h_axis (
    .clk     (clk),
    .i_sclr  (i_sclr),
    .i_step  (i_px_clk),
    .o_state (h_state),
    .o_count (h_count),
    .o_wrap  (h_wrap),
    .o_active(h_active),
    .o_sync  (h_sync)
  );

  // Vertical axis advances only on the strobe that wraps the line.
  vga_axis_fsm #(
    .ACTIVE_LEN(V_ACTIVE),
    .FRONT_LEN (V_FP),
    .SYNC_LEN  (V_SYNC),
    .BACK_LEN  (V_BP)
  ) u_v_axis (
    .clk     (clk),
    .i_sclr  (i_sclr),
    .i_step  (h_wrap),
    .o_state (v_state),
    .o_count (v_count),
    .o_wrap  (v_wrap),
    .o_active(v_active),
    .o_sync  (v_sync)
  );

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_line_start  <= h_wrap;
      o_frame_start <= h_wrap && v_wrap;
    end
  end

  assign o_hsync_en = h_sync;
  assign o_vsync_en = v_sync;
  assign o_vga_hs   = ~h_sync;
  assign o_vga_vs   = ~v_sync;
  assign o_haddr_en = h_active;
  assign o_vaddr_en = v_active;
  assign o_hidx     = h_active ? h_count : '0;
  // Active line index never exceeds 511, so the counter MSB is zero here.
  assign o_vidx     = v_active ? v_count[8:0] : '0;

  assign state_unused = ^{h_state, v_state, v_count[CNT_W-1]};

endmodule
